// File: rtl/alu_arbiter.sv
// Two-requester arbitrated 4-bit ALU: IDLE -> EXEC -> DONE, alternating priority on contention.
// Optional per-requester completion counters are enabled with the ALU_ARB_STATS_EN macro.
module alu_arbiter #(
    parameter bit FIRST_PRIO = 1'b0
) (
    input  logic       Clock,
    input  logic       Reset_b,
    input  logic       Req0,
    input  logic [3:0] A0,
    input  logic [3:0] B0,
    input  logic [1:0] Func0,
    input  logic       Req1,
    input  logic [3:0] A1,
    input  logic [3:0] B1,
    input  logic [1:0] Func1,
    output logic       Ack0,
    output logic       Ack1,
    output logic [7:0] Result,
    output logic       Busy,
`ifdef ALU_ARB_STATS_EN
    output logic [7:0] Count0,
    output logic [7:0] Count1,
`endif
    output logic       Owner
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state, state_nxt;
    logic       owner, prio, grant, load;
    logic       ack0, ack1, busy;
    logic [3:0] a_p0, b_p0;
    logic [1:0] func_p0;
    logic [7:0] result_p1;

    function automatic logic [7:0] alu_op(input logic [3:0] a, input logic [3:0] b,
                                          input logic [1:0] f);
        logic [4:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        case (f)
            2'b00:   alu_op = {3'b000, sum};
            2'b01:   alu_op = {4'b0000, a | b};
            2'b10:   alu_op = {4'b0000, a & b};
            default: alu_op = {a, b};
        endcase
    endfunction

    always_comb begin
        state_nxt = state;
        grant     = prio;
        load      = 1'b0;
        ack0      = 1'b0;
        ack1      = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                if (Req0 || Req1) begin
                    load      = 1'b1;
                    state_nxt = EXEC;
                    // Priority only matters on a tie; a lone request always wins.
                    grant     = (Req0 && Req1) ? prio : Req1;
                end
            end
            EXEC: begin
                busy      = 1'b1;
                state_nxt = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                ack0      = ~owner;
                ack1      = owner;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!Reset_b) begin
            state <= IDLE;
            owner <= FIRST_PRIO;
            prio  <= FIRST_PRIO;
        end else begin
            state <= state_nxt;
            if (load)
                owner <= grant;
            if (state == DONE)
                prio <= ~owner;
        end
    end

    // Stage p0: operand latch on grant
    always_ff @(posedge Clock) begin
        if (!Reset_b) begin
            a_p0    <= '0;
            b_p0    <= '0;
            func_p0 <= '0;
        end else if (load) begin
            a_p0    <= grant ? A1 : A0;
            b_p0    <= grant ? B1 : B0;
            func_p0 <= grant ? Func1 : Func0;
        end
    end

    // Stage p1: registered ALU result, held until the next operation
    always_ff @(posedge Clock) begin
        if (!Reset_b)
            result_p1 <= '0;
        else if (state == EXEC)
            result_p1 <= alu_op(a_p0, b_p0, func_p0);
    end

`ifdef ALU_ARB_STATS_EN
    logic [7:0] count0, count1;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        sat_inc = (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    always_ff @(posedge Clock) begin
        if (!Reset_b) begin
            count0 <= '0;
            count1 <= '0;
        end else begin
            if (ack0)
                count0 <= sat_inc(count0);
            if (ack1)
                count1 <= sat_inc(count1);
        end
    end

    assign Count0 = count0;
    assign Count1 = count1;
`endif

    assign Ack0   = ack0;
    assign Ack1   = ack1;
    assign Busy   = busy;
    assign Owner  = owner;
    assign Result = result_p1;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter; define ALU_ARB_STATS_EN to also exercise the counters.
module tb_alu_arbiter;

    logic       Clock = 1'b0;
    logic       Reset_b;
    logic       Req0, Req1;
    logic [3:0] A0, B0, A1, B1;
    logic [1:0] Func0, Func1;
    logic       Ack0, Ack1, Busy, Owner;
    logic [7:0] Result;
`ifdef ALU_ARB_STATS_EN
    logic [7:0] Count0, Count1;
`endif

    int nvec = 0;
    int nerr = 0;

    alu_arbiter #(.FIRST_PRIO(1'b0)) dut (
        .Clock  (Clock),
        .Reset_b(Reset_b),
        .Req0   (Req0),
        .A0     (A0),
        .B0     (B0),
        .Func0  (Func0),
        .Req1   (Req1),
        .A1     (A1),
        .B1     (B1),
        .Func1  (Func1),
        .Ack0   (Ack0),
        .Ack1   (Ack1),
        .Result (Result),
        .Busy   (Busy),
`ifdef ALU_ARB_STATS_EN
        .Count0 (Count0),
        .Count1 (Count1),
`endif
        .Owner  (Owner)
    );

    always #5 Clock = ~Clock;

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        nvec++;
        assert (obs === exp)
        else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One uncontended operation starting from IDLE; leaves the bench in IDLE with Req dropped.
    task automatic single_op(input logic who, input logic [3:0] a, input logic [3:0] b,
                             input logic [1:0] f, input logic [7:0] exp);
        if (who) begin Req1 = 1'b1; A1 = a; B1 = b; Func1 = f; end
        else     begin Req0 = 1'b1; A0 = a; B0 = b; Func0 = f; end
        tick();
        check("op_exec_busy", Busy, 1'b1);
        check("op_owner", Owner, who);
        check("op_no_early_ack", Ack0 | Ack1, 1'b0);
        tick();
        check("op_ack0", Ack0, !who);
        check("op_ack1", Ack1, who);
        check("op_result", Result, exp);
        Req0 = 1'b0;
        Req1 = 1'b0;
        tick();
        check("op_idle_busy", Busy, 1'b0);
        check("op_idle_noack", Ack0 | Ack1, 1'b0);
        check("op_result_hold", Result, exp);
    endtask

    initial begin
        logic exp_who;
        Reset_b = 1'b0;
        Req0 = 1'b0; A0 = 4'h0; B0 = 4'h0; Func0 = 2'b00;
        Req1 = 1'b0; A1 = 4'h0; B1 = 4'h0; Func1 = 2'b00;
        tick();
        tick();
        check("rst_ack0", Ack0, 1'b0);
        check("rst_ack1", Ack1, 1'b0);
        check("rst_busy", Busy, 1'b0);
        check("rst_result", Result, 8'h00);
        check("rst_owner", Owner, 1'b0);
        Reset_b = 1'b1;
        tick();
        check("idle_no_req", Busy, 1'b0);

        single_op(1'b0, 4'hF, 4'hF, 2'b00, 8'h1E);
        single_op(1'b1, 4'hA, 4'h5, 2'b11, 8'hA5);
        single_op(1'b1, 4'hA, 4'h5, 2'b01, 8'h0F);
        single_op(1'b1, 4'hA, 4'h5, 2'b10, 8'h00);

        // Continuous contention: priority is back at requester 0 here.
        A0 = 4'h1; B0 = 4'h2; Func0 = 2'b00;
        A1 = 4'h2; B1 = 4'h3; Func1 = 2'b11;
        Req0 = 1'b1; Req1 = 1'b1;
        for (int k = 0; k < 6; k++) begin
            exp_who = k[0];
            tick();
            check("cont_busy", Busy, 1'b1);
            check("cont_owner", Owner, exp_who);
            tick();
            check("cont_ack0", Ack0, !exp_who);
            check("cont_ack1", Ack1, exp_who);
            check("cont_result", Result, exp_who ? 8'h23 : 8'h03);
            if (k == 5) begin Req0 = 1'b0; Req1 = 1'b0; end
            tick();
            check("cont_gap", Busy, 1'b0);
        end

        // Operand change after latch must not reach Result.
        Req0 = 1'b1; A0 = 4'h3; B0 = 4'h4; Func0 = 2'b00;
        tick();
        A0 = 4'hF;
        tick();
        check("latch_ack0", Ack0, 1'b1);
        check("latch_result", Result, 8'h07);
        Req0 = 1'b0;
        tick();

        // Reset during EXEC for requester 1 (priority currently 1).
        Req1 = 1'b1; A1 = 4'h9; B1 = 4'h9; Func1 = 2'b11;
        tick();
        check("abort_owner", Owner, 1'b1);
        Reset_b = 1'b0;
        Req0 = 1'b1; A0 = 4'h6; B0 = 4'h7; Func0 = 2'b00;
        tick();
        check("abort_busy", Busy, 1'b0);
        check("abort_ack", Ack0 | Ack1, 1'b0);
        check("abort_result", Result, 8'h00);
        check("abort_owner_rst", Owner, 1'b0);
        // Both pending at release: restored priority gives requester 0 the grant.
        Reset_b = 1'b1;
        tick();
        check("post_rst_owner", Owner, 1'b0);
        check("post_rst_busy", Busy, 1'b1);
        check("post_rst_noack", Ack1, 1'b0);
        tick();
        check("post_rst_ack0", Ack0, 1'b1);
        check("post_rst_ack1", Ack1, 1'b0);
        check("post_rst_result", Result, 8'h0D);
        Req0 = 1'b0; Req1 = 1'b0;
        tick();

`ifdef ALU_ARB_STATS_EN
        Reset_b = 1'b0;
        tick();
        Reset_b = 1'b1;
        Req0 = 1'b1;
        for (int k = 0; k < 300; k++) begin
            tick();
            tick();
            if (k == 299) Req0 = 1'b0;
            tick();
        end
        check("cnt0_sat", Count0, 8'hFF);
        check("cnt1_zero", Count1, 8'h00);
        Reset_b = 1'b0;
        tick();
        check("cnt0_rst", Count0, 8'h00);
        check("cnt1_rst", Count1, 8'h00);
        Reset_b = 1'b1;
        tick();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
